reg_share_arbiter: RTL and testbench

//   Round-robin arbiter that shares one DFF-based storage register among NUM_REQ

---
 rtl/reg_share_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// reg_share_arbiter: round-robin arbiter granting one write slot per grant into a
// shared DFF register, with optional bounded lock bursts by the granted requester.
module reg_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW = 8,
  parameter int MAX_LOCK = 16,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_lock,
  input  logic [NUM_REQ*DW-1:0]      i_wdata,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [DW-1:0]              o_q,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_lock_to
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [IW-1:0]   cur, next_cur;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   lock_cnt, next_cnt;
  logic [NUM_REQ-1:0] next_gnt;
  logic            next_lock_to;
  logic            write_en;
  logic            rearb;
  logic [IW-1:0]   cur_inc;
  logic [IW-1:0]   base;
  logic [IW-1:0]   win;
  logic            found;

  assign o_busy   = (state != S_IDLE);
  assign write_en = o_busy && i_req[cur];
  assign cur_inc  = (cur == LAST) ? '0 : cur + IW'(1);
  // Arbitration starts after the writer on a write edge, otherwise from the held pointer.
  assign base     = write_en ? cur_inc : ptr;

  always_comb begin
    int idx;
    logic [IW-1:0] sel;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IW'(idx);
      if (!found && i_req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    next_state   = state;
    next_cur     = cur;
    next_gnt     = o_gnt;
    next_cnt     = lock_cnt;
    next_lock_to = 1'b0;
    rearb        = 1'b0;
    case (state)
      S_IDLE: rearb = 1'b1;
      S_GRANT: begin
        if (i_req[cur] && i_lock[cur]) begin
          next_state = S_LOCK;
          next_cnt   = CW'(1);
        end else begin
          rearb = 1'b1;
        end
      end
      S_LOCK: begin
        if (!i_req[cur] || !i_lock[cur]) begin
          rearb = 1'b1;
        end else if (lock_cnt == CW'(MAX_LOCK)) begin
          rearb        = 1'b1;
          next_lock_to = 1'b1;
        end else begin
          next_cnt = lock_cnt + CW'(1);
        end
      end
      default: rearb = 1'b1;
    endcase
    if (rearb) begin
      next_cnt = '0;
      if (found) begin
        next_state = S_GRANT;
        next_cur   = win;
        next_gnt   = NUM_REQ'(1) << win;
      end else begin
        next_state = S_IDLE;
        next_gnt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      cur       <= '0;
      ptr       <= '0;
      lock_cnt  <= '0;
      o_gnt     <= '0;
      o_q       <= RST_VAL;
      o_owner   <= '0;
      o_valid   <= 1'b0;
      o_lock_to <= 1'b0;
    end else begin
      state     <= next_state;
      cur       <= next_cur;
      lock_cnt  <= next_cnt;
      o_gnt     <= next_gnt;
      o_lock_to <= next_lock_to;
      if (write_en) begin
        o_q     <= i_wdata[int'(cur)*DW +: DW];
        o_owner <= cur;
        o_valid <= 1'b1;
        ptr     <= cur_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// tb_reg_share_arbiter: directed table, corner sequences and random traffic checked
// against a transaction-level model of the shared-register arbiter.
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int MAXL = 4;
  localparam logic [7:0] RSTV = 8'h5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]  gnt;
  logic [DW-1:0] q;
  logic [1:0]    owner;
  logic          valid, busy, lock_to;

  int n_cmp = 0;
  int n_bad = 0;

  reg_share_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_LOCK(MAXL), .RST_VAL(RSTV)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_req(req), .i_lock(lock), .i_wdata(wdata),
    .o_gnt(gnt), .o_q(q), .o_owner(owner), .o_valid(valid), .o_busy(busy),
    .o_lock_to(lock_to)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the register, how long it has been locked, pointer.
  int m_ptr, m_g, m_cnt, m_owner;
  bit m_busy, m_locked, m_to, m_valid;
  logic [7:0] m_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_g = 0; m_cnt = 0; m_owner = 0;
    m_busy = 0; m_locked = 0; m_to = 0; m_valid = 0; m_q = RSTV;
  endtask

  task automatic model_step();
    bit rearb;
    bit to;
    rearb = 0;
    to = 0;
    if (m_busy && req[m_g]) begin
      m_q = wdata[m_g*DW +: DW];
      m_owner = m_g;
      m_valid = 1;
      m_ptr = (m_g + 1) % N;
    end
    if (!m_busy) rearb = 1;
    else if (!m_locked) begin
      if (req[m_g] && lock[m_g]) begin m_locked = 1; m_cnt = 1; end
      else rearb = 1;
    end
    else if (!req[m_g] || !lock[m_g]) rearb = 1;
    else if (m_cnt == MAXL) begin rearb = 1; to = 1; end
    else m_cnt++;
    m_to = to;
    if (rearb) begin
      m_locked = 0;
      m_busy = 0;
      for (int k = 0; k < N; k++)
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_busy = 1;
          m_g = (m_ptr + k) % N;
        end
    end
  endtask

  task automatic check_model();
    chk("gnt", 32'(gnt), m_busy ? 32'(1) << m_g : 32'd0);
    chk("q", 32'(q), 32'(m_q));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("lock_to", 32'(lock_to), 32'(m_to));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; lock = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [7:0] q;
    int         owner;
  } vec_t;
  vec_t tbl[13];

  initial begin
    // Fairness, idle and lock-burst rows; expected values are post-edge outputs.
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 8'h5A, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 8'hA0, 0};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 8'hA1, 1};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 8'hA2, 2};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 8'hA3, 3};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 8'hA3, 3};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 8'hA3, 3};
    tbl[7]  = '{4'b0010, 4'b0010, 4'b0010, 8'hA3, 3};
    tbl[8]  = '{4'b0011, 4'b0010, 4'b0010, 8'hA1, 1};
    tbl[9]  = '{4'b0011, 4'b0010, 4'b0010, 8'hA1, 1};
    tbl[10] = '{4'b0011, 4'b0010, 4'b0010, 8'hA1, 1};
    tbl[11] = '{4'b0011, 4'b0000, 4'b0001, 8'hA1, 1};
    tbl[12] = '{4'b0001, 4'b0000, 4'b0001, 8'hA0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("rst_q", 32'(q), 32'(RSTV));
    @(negedge clk);
    rst_n = 1'b1;

    wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      lock = tbl[i].lock;
      cycle();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
    end

    // Timeout with req3 pending, then timeout with req2 alone.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req = (v == 0) ? 4'b1100 : 4'b0100;
      lock = 4'b0100;
      for (int c = 1; c <= 7; c++) begin
        cycle();
        if (c <= 5) chk("to_gnt_hold", 32'(gnt), 32'h4);
        if (c != 6) chk("to_pulse_low", 32'(lock_to), 32'd0);
        if (c == 6) begin
          chk("to_pulse", 32'(lock_to), 32'd1);
          chk("to_next_gnt", 32'(gnt), (v == 0) ? 32'h8 : 32'h4);
        end
      end
    end

    // Withdrawal: req3 drops during GRANT, pointer stays at 1 so req2 beats req0.
    do_reset();
    req = 4'b0001;
    cycle();
    cycle();
    req = 4'b0000;
    cycle();
    cycle();
    req = 4'b1000;
    cycle();
    chk("wd_gnt3", 32'(gnt), 32'h8);
    req = 4'b0101;
    wdata = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    cycle();
    chk("wd_gnt2", 32'(gnt), 32'h4);
    chk("wd_q_hold", 32'(q), 32'hA0);
    chk("wd_owner_hold", 32'(owner), 32'd0);

    // Asynchronous reset in the middle of a lock burst.
    do_reset();
    req = 4'b0010;
    lock = 4'b0010;
    repeat (3) cycle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_q", 32'(q), 32'(RSTV));
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; requests persist for several cycles to exercise timeouts.
    req = '0;
    lock = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      lock = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      wdata = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
